// File: rtl/iod_ref_clk_train_ctrl.sv
// iod_ref_clk_train_ctrl: sweeps the IOD delay line to find two data edges and centres on their midpoint.
// Optional post-centring eye-monitor check is enabled by defining IOD_TRAIN_EYE_CHECK_EN.
module iod_ref_clk_train_ctrl #(
    parameter int SETTLE_CYCLES = 8,
    parameter int MAX_TAPS      = 127
) (
    input  logic       FAB_CLK,
    input  logic       ARST_N,
    input  logic       TRAIN_START,
    input  logic [7:0] RX_DATA,
    input  logic       DELAY_LINE_OUT_OF_RANGE,
    input  logic       EYE_MONITOR_EARLY,
    input  logic       EYE_MONITOR_LATE,
    output logic       DELAY_LINE_LOAD,
    output logic       DELAY_LINE_MOVE,
    output logic       DELAY_LINE_DIRECTION,
    output logic       EYE_MONITOR_CLEAR_FLAGS,
    output logic       BUSY,
    output logic       TRAIN_DONE,
    output logic       TRAIN_ERR,
    output logic [7:0] TAP_COUNT
);
    typedef enum logic [3:0] {IDLE, LOAD, SETTLE, SAMPLE, STEP, CENTER, CHECK, DONE, ERROR} state_t;
    state_t     state_q, state_d;
    logic [7:0] tap_q, tap_d, ref_q, ref_d, e1_q, e1_d, e2_q, e2_d, cnt_q, cnt_d;
    logic       phase_q, phase_d, dir_q, dir_d;
    logic [7:0] target;
    logic       rx_edge, at_max;
    assign target  = 8'(({1'b0, e1_q} + {1'b0, e2_q}) >> 1);
    // At tap 0 the sample becomes the reference, so it can never count as an edge
    assign rx_edge = (tap_q != 8'd0) && (RX_DATA != ref_q);
    assign at_max  = tap_q == 8'(MAX_TAPS);
`ifndef IOD_TRAIN_EYE_CHECK_EN
    logic unused_eye;
    assign unused_eye = EYE_MONITOR_EARLY | EYE_MONITOR_LATE;
`endif
    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            state_q <= IDLE;
            tap_q   <= '0;
            ref_q   <= '0;
            e1_q    <= '0;
            e2_q    <= '0;
            cnt_q   <= '0;
            phase_q <= 1'b0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tap_q   <= tap_d;
            ref_q   <= ref_d;
            e1_q    <= e1_d;
            e2_q    <= e2_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            dir_q   <= dir_d;
        end
    end
    always_comb begin
        state_d = state_q;
        tap_d   = tap_q;
        ref_d   = ref_q;
        e1_d    = e1_q;
        e2_d    = e2_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        dir_d   = dir_q;
        case (state_q)
            IDLE, DONE, ERROR: state_d = TRAIN_START ? LOAD : state_q;
            LOAD: begin
                tap_d   = '0;
                phase_d = 1'b0;
                cnt_d   = '0;
                state_d = SETTLE;
            end
            SETTLE: begin
                cnt_d   = (cnt_q == 8'(SETTLE_CYCLES - 1)) ? 8'd0 : cnt_q + 8'd1;
                state_d = (cnt_q == 8'(SETTLE_CYCLES - 1)) ? SAMPLE : SETTLE;
            end
            SAMPLE: begin
                if (tap_q == 8'd0) ref_d = RX_DATA;
                if (DELAY_LINE_OUT_OF_RANGE) begin
                    state_d = ERROR;
                end else if (rx_edge && !phase_q) begin
                    e1_d    = tap_q;
                    ref_d   = RX_DATA;
                    phase_d = 1'b1;
                    state_d = at_max ? ERROR : STEP;
                end else if (rx_edge) begin
                    e2_d    = tap_q;
                    state_d = CENTER;
                end else begin
                    state_d = at_max ? ERROR : STEP;
                end
            end
            STEP: begin
                tap_d   = tap_q + 8'd1;
                dir_d   = 1'b1;
                cnt_d   = '0;
                state_d = SETTLE;
            end
            // E2 > E1 always, so at least one decrement happens before reaching the midpoint
            CENTER: begin
                tap_d   = tap_q - 8'd1;
                dir_d   = 1'b0;
                cnt_d   = '0;
                state_d = (tap_q - 8'd1 == target) ? CHECK : CENTER;
            end
            CHECK: begin
`ifdef IOD_TRAIN_EYE_CHECK_EN
                cnt_d   = cnt_q + 8'd1;
                if (cnt_q == 8'(SETTLE_CYCLES))
                    state_d = (EYE_MONITOR_EARLY || EYE_MONITOR_LATE) ? ERROR : DONE;
`else
                state_d = DONE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        DELAY_LINE_LOAD         = state_q == LOAD;
        DELAY_LINE_MOVE         = (state_q == STEP) || (state_q == CENTER);
        DELAY_LINE_DIRECTION    = (state_q == STEP) ? 1'b1 : (state_q == CENTER) ? 1'b0 : dir_q;
`ifdef IOD_TRAIN_EYE_CHECK_EN
        EYE_MONITOR_CLEAR_FLAGS = ((state_q == SETTLE) || (state_q == CHECK)) && (cnt_q == 8'd0);
`else
        EYE_MONITOR_CLEAR_FLAGS = (state_q == SETTLE) && (cnt_q == 8'd0);
`endif
        BUSY                    = !((state_q == IDLE) || (state_q == DONE) || (state_q == ERROR));
        TRAIN_DONE              = state_q == DONE;
        TRAIN_ERR               = state_q == ERROR;
        TAP_COUNT               = tap_q;
    end
endmodule

// File: tb/tb_iod_ref_clk_train_ctrl.sv
// tb_iod_ref_clk_train_ctrl: randomized and directed training runs against a tap-scan reference model.
// The bench models the IOD delay line: RX_DATA follows a per-tap pattern at the current tap position.
module tb_iod_ref_clk_train_ctrl;
    logic       FAB_CLK = 1'b0, ARST_N = 1'b0, TRAIN_START = 1'b0;
    logic [7:0] RX_DATA;
    logic       DELAY_LINE_OUT_OF_RANGE, EYE_MONITOR_EARLY = 1'b0, EYE_MONITOR_LATE = 1'b0;
    logic       DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, EYE_MONITOR_CLEAR_FLAGS;
    logic       BUSY, TRAIN_DONE, TRAIN_ERR;
    logic [7:0] TAP_COUNT;
    logic [7:0] pattern [256];
    int         pos = 0, n_load = 0, n_inc = 0, n_dec = 0, oor_tap = 1000;
    int         checks = 0, passes = 0;

    iod_ref_clk_train_ctrl dut (
        .FAB_CLK(FAB_CLK), .ARST_N(ARST_N), .TRAIN_START(TRAIN_START), .RX_DATA(RX_DATA),
        .DELAY_LINE_OUT_OF_RANGE(DELAY_LINE_OUT_OF_RANGE), .EYE_MONITOR_EARLY(EYE_MONITOR_EARLY),
        .EYE_MONITOR_LATE(EYE_MONITOR_LATE), .DELAY_LINE_LOAD(DELAY_LINE_LOAD),
        .DELAY_LINE_MOVE(DELAY_LINE_MOVE), .DELAY_LINE_DIRECTION(DELAY_LINE_DIRECTION),
        .EYE_MONITOR_CLEAR_FLAGS(EYE_MONITOR_CLEAR_FLAGS), .BUSY(BUSY), .TRAIN_DONE(TRAIN_DONE),
        .TRAIN_ERR(TRAIN_ERR), .TAP_COUNT(TAP_COUNT)
    );

    always #5 FAB_CLK = ~FAB_CLK;

    assign RX_DATA = pattern[pos[7:0]];
    assign DELAY_LINE_OUT_OF_RANGE = pos >= oor_tap;

    always @(posedge FAB_CLK) begin
        if (DELAY_LINE_LOAD) begin
            pos    <= 0;
            n_load <= n_load + 1;
            n_inc  <= 0;
            n_dec  <= 0;
        end else if (DELAY_LINE_MOVE && DELAY_LINE_DIRECTION) begin
            pos   <= pos + 1;
            n_inc <= n_inc + 1;
        end else if (DELAY_LINE_MOVE) begin
            pos   <= pos - 1;
            n_dec <= n_dec + 1;
        end
    end

    // Scan taps 0..127 the way training is described: first change from tap 0 is E1,
    // next change after that is E2, land on floor((E1+E2)/2).
    function automatic void model(output bit err, output int tap, output int inc, output int dec);
        int e1 = -1;
        logic [7:0] r = pattern[0];
        dec = 0;
        for (int t = 0; t <= 127; t++) begin
            inc = t;
            if (t >= oor_tap) begin
                err = 1; tap = t;
                return;
            end
            if (pattern[t] != r) begin
                if (e1 < 0) begin
                    e1 = t; r = pattern[t];
                end else begin
                    tap = (e1 + t) / 2;
                    dec = t - tap;
`ifdef IOD_TRAIN_EYE_CHECK_EN
                    err = EYE_MONITOR_EARLY | EYE_MONITOR_LATE;
`else
                    err = 0;
`endif
                    return;
                end
            end
        end
        err = 1; tap = 127;
    endfunction

    task automatic run_train(output bit timeout);
        int n = 0;
        @(negedge FAB_CLK) TRAIN_START = 1'b1;
        @(negedge FAB_CLK) TRAIN_START = 1'b0;
        while (BUSY && n < 4000) begin
            @(negedge FAB_CLK);
            n++;
        end
        timeout = BUSY;
    endtask

    task automatic set_pattern(input int e1, input int e2, input logic [7:0] v0, v1, v2);
        for (int t = 0; t < 256; t++) pattern[t] = (t < e1) ? v0 : (t < e2) ? v1 : v2;
    endtask

    task automatic test_train(input string name, input int e1, e2, input logic [7:0] v0, v1, v2, input int oor);
        bit to, err;
        int tap, inc, dec, loads0;
        set_pattern(e1, e2, v0, v1, v2);
        oor_tap = oor;
        model(err, tap, inc, dec);
        loads0 = n_load;
        run_train(to);
        checks++; if (to) $display("FAIL %s timeout: BUSY=1 want 0", name); else passes++;
        checks++; if (TRAIN_DONE !== !err) $display("FAIL %s done: got %b want %b", name, TRAIN_DONE, !err); else passes++;
        checks++; if (TRAIN_ERR !== err) $display("FAIL %s err: got %b want %b", name, TRAIN_ERR, err); else passes++;
        checks++; if (TAP_COUNT !== 8'(tap)) $display("FAIL %s tap: got %0d want %0d", name, TAP_COUNT, tap); else passes++;
        checks++; if (n_inc != inc) $display("FAIL %s inc_pulses: got %0d want %0d", name, n_inc, inc); else passes++;
        checks++; if (n_dec != dec) $display("FAIL %s dec_pulses: got %0d want %0d", name, n_dec, dec); else passes++;
        checks++; if (n_load - loads0 != 1) $display("FAIL %s loads: got %0d want 1", name, n_load - loads0); else passes++;
        oor_tap = 1000;
    endtask

    task automatic test_reset();
        logic [14:0] o;
        #3 o = {DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, EYE_MONITOR_CLEAR_FLAGS, BUSY, TRAIN_DONE, TRAIN_ERR, TAP_COUNT};
        checks++; if (o !== 15'd0) $display("FAIL reset_outputs: got %h want 0", o); else passes++;
        @(negedge FAB_CLK) ARST_N = 1'b1;
        repeat (3) @(negedge FAB_CLK);
        o = {DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, EYE_MONITOR_CLEAR_FLAGS, BUSY, TRAIN_DONE, TRAIN_ERR, TAP_COUNT};
        checks++; if (o !== 15'd0) $display("FAIL idle_after_release: got %h want 0", o); else passes++;
    endtask

    task automatic test_reset_in_center();
        logic [14:0] o;
        int n = 0;
        set_pattern(20, 60, 8'h0F, 8'hF0, 8'h0F);
        @(negedge FAB_CLK) TRAIN_START = 1'b1;
        @(negedge FAB_CLK) TRAIN_START = 1'b0;
        while (!(DELAY_LINE_MOVE && !DELAY_LINE_DIRECTION) && n < 4000) begin
            @(negedge FAB_CLK);
            n++;
        end
        checks++; if (n >= 4000) $display("FAIL center_reached: got timeout want decrement move"); else passes++;
        repeat (5) @(negedge FAB_CLK);
        ARST_N = 1'b0;
        #1 o = {DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, EYE_MONITOR_CLEAR_FLAGS, BUSY, TRAIN_DONE, TRAIN_ERR, TAP_COUNT};
        checks++; if (o !== 15'd0) $display("FAIL reset_in_center: got %h want 0", o); else passes++;
        @(negedge FAB_CLK) ARST_N = 1'b1;
        test_train("retrain_after_reset", 20, 60, 8'h0F, 8'hF0, 8'h0F, 1000);
    endtask

    task automatic test_start_ignored();
        int loads0, n = 0;
        set_pattern(20, 60, 8'h0F, 8'hF0, 8'h0F);
        loads0 = n_load;
        @(negedge FAB_CLK) TRAIN_START = 1'b1;
        @(negedge FAB_CLK) TRAIN_START = 1'b0;
        repeat (150) @(negedge FAB_CLK);
        TRAIN_START = 1'b1;
        @(negedge FAB_CLK) TRAIN_START = 1'b0;
        while (BUSY && n < 4000) begin
            @(negedge FAB_CLK);
            n++;
        end
        checks++; if (n_load - loads0 != 1) $display("FAIL start_ignored_loads: got %0d want 1", n_load - loads0); else passes++;
        checks++; if (TAP_COUNT !== 8'd40 || TRAIN_DONE !== 1'b1) $display("FAIL start_ignored_result: got tap %0d done %b want 40 1", TAP_COUNT, TRAIN_DONE); else passes++;
    endtask

    task automatic test_eye_check();
        EYE_MONITOR_LATE = 1'b1;
        test_train("eye_late", 20, 60, 8'h0F, 8'hF0, 8'h0F, 1000);
        EYE_MONITOR_LATE = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            int e1 = $urandom_range(1, 80);
            int e2 = $urandom_range(e1 + 1, 126);
            logic [7:0] v0 = 8'($urandom), v1 = v0 ^ 8'($urandom_range(1, 255)), v2 = v1 ^ 8'($urandom_range(1, 255));
            int oor = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 126) : 1000;
            test_train($sformatf("random%0d", i), e1, e2, v0, v1, v2, oor);
        end
    endtask

    initial begin
        test_reset();
        test_train("edges_20_60", 20, 60, 8'h0F, 8'hF0, 8'h0F, 1000);
        test_train("edges_21_60", 21, 60, 8'h0F, 8'hF0, 8'h0F, 1000);
        test_train("no_edge", 1000, 1000, 8'h0F, 8'h0F, 8'h0F, 1000);
        test_train("out_of_range_50", 20, 60, 8'h0F, 8'hF0, 8'h0F, 50);
        test_reset_in_center();
        test_start_ignored();
        test_eye_check();
        test_train("back_to_back", 5, 6, 8'h00, 8'h01, 8'h00, 1000);
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/iod_ref_clk_train_ctrl.md
IOD_REF_CLK_TRAIN_CTRL -- requirements
Module: iod_ref_clk_train_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 8, meaning wait cycles after each delay-line load/move before sampling (legal range 1..255).
REQ-002 SHALL have parameter MAX_TAPS, default 127, meaning last tap index searched (legal range 2..255).
REQ-003 SHALL have port FAB_CLK  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port ARST_N  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port TRAIN_START  input  1  one-cycle request to (re)train.
REQ-006 SHALL have port RX_DATA  input  8  deserialised reference-clock sample from IOD.
REQ-007 SHALL have port DELAY_LINE_OUT_OF_RANGE  input  1  IOD delay-line limit flag.
REQ-008 SHALL have port EYE_MONITOR_EARLY  input  1  IOD eye-monitor early flag.
REQ-009 SHALL have port EYE_MONITOR_LATE  input  1  IOD eye-monitor late flag.
REQ-010 SHALL have port DELAY_LINE_LOAD  output  1  reload delay line to its configured value.
REQ-011 SHALL have port DELAY_LINE_MOVE  output  1  one-tap move strobe.
REQ-012 SHALL have port DELAY_LINE_DIRECTION  output  1  1 = increment, 0 = decrement.
REQ-013 SHALL have port EYE_MONITOR_CLEAR_FLAGS  output  1  clear eye-monitor flags.
REQ-014 SHALL have port BUSY  output  1  training in progress.
REQ-015 SHALL have port TRAIN_DONE  output  1  training succeeded; level.
REQ-016 SHALL have port TRAIN_ERR  output  1  training failed; level.
REQ-017 SHALL have port TAP_COUNT  output  8  current tap offset from the loaded position.

Function
REQ-018 SHALL implement FSM states IDLE, LOAD, SETTLE, SAMPLE, STEP, CENTER, CHECK, DONE, ERROR.
REQ-019 SHALL, in IDLE, DONE or ERROR, move to LOAD on TRAIN_START=1; TRAIN_START SHALL be ignored in all other states.
REQ-020 SHALL, in LOAD (one cycle), assert DELAY_LINE_LOAD, clear TAP_COUNT, phase, TRAIN_DONE and TRAIN_ERR, and go to SETTLE.
REQ-021 SHALL, in SETTLE, assert EYE_MONITOR_CLEAR_FLAGS on its first cycle only, remain exactly SETTLE_CYCLES cycles, then go to SAMPLE.
REQ-022 SHALL, in SAMPLE (one cycle), go to ERROR if DELAY_LINE_OUT_OF_RANGE=1; this check takes priority over edge detection.
REQ-023 SHALL, in SAMPLE at TAP_COUNT=0, store RX_DATA as reference byte REF.
REQ-024 SHALL, in SAMPLE at phase 0, when RX_DATA differs from REF: store E1=TAP_COUNT, set REF=RX_DATA, set phase 1.
REQ-025 SHALL, in SAMPLE at phase 1, when RX_DATA differs from REF: store E2=TAP_COUNT and go to CENTER.
REQ-026 SHALL, in SAMPLE with no edge found, go to ERROR if TAP_COUNT=MAX_TAPS, else go to STEP.
REQ-027 SHALL, in STEP (one cycle), assert DELAY_LINE_MOVE with DELAY_LINE_DIRECTION=1, increment TAP_COUNT, and go to SETTLE.
REQ-028 SHALL, on CENTER entry, compute TARGET=(E1+E2)>>1 using a 9-bit sum, floor rounding.
REQ-029 SHALL, in CENTER, assert DELAY_LINE_MOVE with DELAY_LINE_DIRECTION=0 for exactly E2-TARGET consecutive cycles, decrementing TAP_COUNT each cycle, then go to CHECK.
REQ-030 SHALL deassert DELAY_LINE_MOVE whenever not in STEP or CENTER; DELAY_LINE_DIRECTION holds its last value.
REQ-031 SHALL hold BUSY=1 in all states except IDLE, DONE and ERROR.
REQ-032 SHALL hold TRAIN_DONE=1 in DONE and TRAIN_ERR=1 in ERROR until the next LOAD; the two SHALL never be 1 together.
REQ-033 SHALL keep TAP_COUNT frozen in DONE and ERROR: final TARGET in DONE, failing tap in ERROR.

Reset
REQ-034 SHALL, on ARST_N=0 at any time including mid-training, immediately enter IDLE and drive all outputs, TAP_COUNT, REF, E1, E2, phase and counters to 0.
REQ-035 SHALL synchronously release reset on the first FAB_CLK edge with ARST_N=1 and remain in IDLE until TRAIN_START.

Configuration
REQ-036 SHALL, with macro IOD_TRAIN_EYE_CHECK_EN defined, implement CHECK as follows: pulse EYE_MONITOR_CLEAR_FLAGS for 1 cycle, wait SETTLE_CYCLES cycles, then go to ERROR if EYE_MONITOR_EARLY or EYE_MONITOR_LATE is 1, else go to DONE.
REQ-037 SHALL, without IOD_TRAIN_EYE_CHECK_EN, make CHECK a single pass-through cycle to DONE, ignore EYE_MONITOR_EARLY and EYE_MONITOR_LATE, and synthesize no CHECK logic beyond that cycle.

Verification
REQ-038 SHALL test edges at taps 20 and 60 (RX_DATA 0x0F, then 0xF0, then 0x0F): expect 60 increment pulses, then 20 decrement pulses, then TRAIN_DONE=1 and TAP_COUNT=40.
REQ-039 SHALL test edges at taps 21 and 60: expect TARGET=40, 20 decrement pulses, TAP_COUNT=40.
REQ-040 SHALL test constant RX_DATA=0x0F: expect TRAIN_ERR=1 and TAP_COUNT=127 with MAX_TAPS=127.
REQ-041 SHALL test DELAY_LINE_OUT_OF_RANGE=1 at tap 50 with an edge also present: expect TRAIN_ERR=1 and TAP_COUNT=50.
REQ-042 SHALL test ARST_N=0 during CENTER: expect all outputs 0 at once; a following TRAIN_START retrains to the same result.
REQ-043 SHALL test, with IOD_TRAIN_EYE_CHECK_EN defined, EYE_MONITOR_LATE=1 after centring: expect TRAIN_ERR=1 and TAP_COUNT=40.
